decode_stage: RTL and testbench

//  RV32I decode stage between fetch and execute. Drives the register-file read

---
 rtl/decode_stage.sv | 180 ++++++++++++++++++
 tb/tb_decode_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, immediate generation, x0/writeback
// forwarding, load-use hazard stall and a valid/ready output pipeline register.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic [4:0]      o_reg_num_1,
  output logic [4:0]      o_reg_num_2,
  input  logic [XLEN-1:0] i_rs_1_val,
  input  logic [XLEN-1:0] i_rs_2_val,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_reg,
  input  logic [XLEN-1:0] i_wb_val,
  input  logic            i_ex_load,
  input  logic [4:0]      i_ex_rd,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic            o_funct7b5,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_op_a,
  output logic [XLEN-1:0] o_op_b,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_legal;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_rd_zero;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic            w_hazard;
  logic            w_ready;
  logic            w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic [XLEN-1:0] r_imm;
  logic            r_illegal;

  assign w_opcode = i_instr[6:0];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];

  // Instruction class: which sources are read, which immediate format applies.
  always_comb begin
    w_legal    = 1'b1;
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    w_rd_zero  = 1'b0;
    w_imm      = '0;
    case (w_opcode)
      OP_LUI, OP_AUIPC: begin
        w_uses_rs1 = 1'b0;
        w_imm      = {i_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        w_uses_rs1 = 1'b0;
        w_imm      = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
        w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_STORE: begin
        w_uses_rs2 = 1'b1;
        w_rd_zero  = 1'b1;
        w_imm      = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OP_BRANCH: begin
        w_uses_rs2 = 1'b1;
        w_rd_zero  = 1'b1;
        w_imm      = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
      end
      OP_REG: begin
        w_uses_rs2 = 1'b1;
      end
      default: begin
        w_legal   = 1'b0;
        w_rd_zero = 1'b1;
      end
    endcase
  end

  // x0 reads as zero; a same-cycle writeback beats the stale register-file data.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] reg_num,
                                          input logic [XLEN-1:0] rf_val);
    if (reg_num == 5'd0)                         return '0;
    else if (i_wb_en && (i_wb_reg == reg_num))   return i_wb_val;
    else                                         return rf_val;
  endfunction

  assign w_op_a = fwd(w_rs1, i_rs_1_val);
  assign w_op_b = fwd(w_rs2, i_rs_2_val);

  assign w_hazard = i_valid & i_ex_load & (i_ex_rd != 5'd0) &
                    ((w_uses_rs1 & (w_rs1 == i_ex_rd)) |
                     (w_uses_rs2 & (w_rs2 == i_ex_rd)));
  assign w_ready  = i_rst & ~w_hazard & (~r_valid | i_ready);
  assign w_accept = i_valid & w_ready & ~i_flush;

  // Output pipeline register; flush wins over accept, accept over drain.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_valid    <= 1'b0;
      r_pc       <= RESET_PC;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_rd       <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_imm      <= '0;
      r_illegal  <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= i_pc;
      r_opcode   <= w_opcode;
      r_funct3   <= i_instr[14:12];
      r_funct7b5 <= i_instr[30];
      r_rd       <= w_rd_zero ? 5'd0 : i_instr[11:7];
      r_op_a     <= w_op_a;
      r_op_b     <= w_op_b;
      r_imm      <= w_imm;
      r_illegal  <= ~w_legal;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ready     = w_ready;
  assign o_reg_num_1 = w_rs1;
  assign o_reg_num_2 = w_rs2;
  assign o_valid     = r_valid;
  assign o_pc        = r_pc;
  assign o_opcode    = r_opcode;
  assign o_funct3    = r_funct3;
  assign o_funct7b5  = r_funct7b5;
  assign o_rd        = r_rd;
  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_imm       = r_imm;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal cases, then randomized traffic
// checked every cycle against a behavioural decode/handshake model.
module tb_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, valid, flush, wb_en, ex_load, ready_in;
  logic [31:0] instr, pc, rs1v, rs2v, wb_val;
  logic [4:0]  wb_reg, ex_rd;
  logic        o_ready, o_valid, o_funct7b5, o_illegal;
  logic [4:0]  o_reg_num_1, o_reg_num_2, o_rd;
  logic [31:0] o_pc, o_op_a, o_op_b, o_imm;
  logic [6:0]  o_opcode;
  logic [2:0]  o_funct3;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_instr(instr), .i_pc(pc), .i_flush(flush),
    .o_reg_num_1(o_reg_num_1), .o_reg_num_2(o_reg_num_2),
    .i_rs_1_val(rs1v), .i_rs_2_val(rs2v),
    .i_wb_en(wb_en), .i_wb_reg(wb_reg), .i_wb_val(wb_val),
    .i_ex_load(ex_load), .i_ex_rd(ex_rd),
    .o_valid(o_valid), .i_ready(ready_in), .o_pc(o_pc), .o_opcode(o_opcode),
    .o_funct3(o_funct3), .o_funct7b5(o_funct7b5), .o_rd(o_rd),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_imm(o_imm), .o_illegal(o_illegal)
  );

  typedef enum int {K_R, K_I, K_S, K_B, K_U, K_J, K_BAD} kind_e;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [31:0] op_a, op_b, imm;
    logic        illegal;
  } dec_t;

  dec_t m_out;
  bit   m_valid = 1'b0;
  bit   m_fresh = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic kind_e kind_of(input logic [6:0] op);
    case (op)
      7'h37, 7'h17:                      return K_U;
      7'h6F:                             return K_J;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: return K_I;
      7'h23:                             return K_S;
      7'h63:                             return K_B;
      7'h33:                             return K_R;
      default:                           return K_BAD;
    endcase
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    kind_e k = kind_of(op);
    return (k == K_R || k == K_S || k == K_B);
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return (v[bits-1]) ? (v | (32'hFFFF_FFFF << bits)) : v;
  endfunction

  // Immediate rebuilt from the bit-position description of each format.
  function automatic logic [31:0] imm_of(input logic [31:0] i);
    logic [31:0] v;
    case (kind_of(i[6:0]))
      K_I: return sext(32'(i >> 20), 12);
      K_S: begin v = 32'((i >> 25) << 5) | 32'((i >> 7) & 32'h1F); return sext(v, 12); end
      K_B: begin
        v = (32'(i[31]) << 12) | (32'(i[7]) << 11) | (32'((i >> 25) & 32'h3F) << 5) |
            (32'((i >> 8) & 32'hF) << 1);
        return sext(v, 13);
      end
      K_U: return i & 32'hFFFF_F000;
      K_J: begin
        v = (32'(i[31]) << 20) | (32'((i >> 12) & 32'hFF) << 12) | (32'(i[20]) << 11) |
            (32'((i >> 21) & 32'h3FF) << 1);
        return sext(v, 21);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'h0;
    if (wb_en && wb_reg == r) return wb_val;
    return rf;
  endfunction

  function automatic bit exp_ready();
    logic [4:0] s1 = instr[19:15];
    logic [4:0] s2 = instr[24:20];
    bit hz = valid && ex_load && ex_rd != 0 &&
             ((reads_rs1(instr[6:0]) && s1 == ex_rd) || (reads_rs2(instr[6:0]) && s2 == ex_rd));
    return rst && !hz && (!m_valid || ready_in);
  endfunction

  function automatic dec_t model_decode();
    dec_t d;
    kind_e k = kind_of(instr[6:0]);
    d.pc      = pc;
    d.opcode  = instr[6:0];
    d.funct3  = instr[14:12];
    d.f7b5    = instr[30];
    d.rd      = (k == K_S || k == K_B || k == K_BAD) ? 5'd0 : instr[11:7];
    d.op_a    = operand(instr[19:15], rs1v);
    d.op_b    = operand(instr[24:20], rs2v);
    d.imm     = imm_of(instr);
    d.illegal = (k == K_BAD);
    return d;
  endfunction

  // Model of what the output register must hold after each edge.
  always @(posedge clk) begin
    bit acc;
    acc = valid && exp_ready() && !flush;
    if (!rst) begin
      m_valid = 1'b0;
      m_fresh = 1'b1;
      m_out   = '{pc: RESET_PC, opcode: 7'h0, funct3: 3'h0, f7b5: 1'b0, rd: 5'h0,
                  op_a: 32'h0, op_b: 32'h0, imm: 32'h0, illegal: 1'b0};
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_fresh = 1'b0;
      m_out   = model_decode();
    end else if (m_valid && ready_in) begin
      m_valid = 1'b0;
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("ready", 32'(o_ready), 32'(exp_ready()));
      check("reg_num_1", 32'(o_reg_num_1), 32'(instr[19:15]));
      check("reg_num_2", 32'(o_reg_num_2), 32'(instr[24:20]));
      check("valid", 32'(o_valid), 32'(m_valid));
      if (m_valid || m_fresh) begin
        check("pc", o_pc, m_out.pc);
        check("opcode", 32'(o_opcode), 32'(m_out.opcode));
        check("funct3", 32'(o_funct3), 32'(m_out.funct3));
        check("funct7b5", 32'(o_funct7b5), 32'(m_out.f7b5));
        check("rd", 32'(o_rd), 32'(m_out.rd));
        check("op_a", o_op_a, m_out.op_a);
        check("op_b", o_op_b, m_out.op_b);
        check("imm", o_imm, m_out.imm);
        check("illegal", 32'(o_illegal), 32'(m_out.illegal));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  initial begin
    rst = 1'b0; valid = 1'b0; flush = 1'b0; wb_en = 1'b0; ex_load = 1'b0;
    ready_in = 1'b1; instr = 32'h0; pc = 32'h0; rs1v = 32'h55; rs2v = 32'h66;
    wb_val = 32'h0; wb_reg = 5'd0; ex_rd = 5'd0;
    repeat (2) tick();
    chk_on = 1'b1;
    check("lit_reset_valid", 32'(o_valid), 32'h0);
    check("lit_reset_pc", o_pc, 32'h0);
    check("lit_reset_ready", 32'(o_ready), 32'h0);
    rst = 1'b1;

    // addi x5,x0,7
    valid = 1'b1; instr = 32'h0070_0293; pc = 32'h100;
    tick();
    check("lit_addi_valid", 32'(o_valid), 32'h1);
    check("lit_addi_rd", 32'(o_rd), 32'd5);
    check("lit_addi_imm", o_imm, 32'd7);
    check("lit_addi_opa", o_op_a, 32'h0);
    check("lit_addi_pc", o_pc, 32'h100);

    // sw x6,8(x2) with x6 forwarded from writeback
    instr = 32'h0061_2423; pc = 32'h104; wb_en = 1'b1; wb_reg = 5'd6; wb_val = 32'hAA;
    rs2v = 32'h11;
    tick();
    check("lit_sw_imm", o_imm, 32'd8);
    check("lit_sw_opb", o_op_b, 32'hAA);
    check("lit_sw_opa", o_op_a, 32'h55);
    check("lit_sw_rd", 32'(o_rd), 32'h0);
    wb_en = 1'b0;

    // beq x1,x2,-4 behind a load to x2
    instr = 32'hFE20_8EE3; pc = 32'h108; ex_load = 1'b1; ex_rd = 5'd2;
    #1 check("lit_beq_stall", 32'(o_ready), 32'h0);
    tick();
    check("lit_beq_bubble", 32'(o_valid), 32'h0);
    ex_load = 1'b0;
    tick();
    check("lit_beq_valid", 32'(o_valid), 32'h1);
    check("lit_beq_imm", o_imm, 32'hFFFF_FFFC);
    check("lit_beq_pc", o_pc, 32'h108);

    // backpressure: hold 3 cycles, then back-to-back transfer
    instr = 32'h0070_0293; pc = 32'h10C;
    tick();
    ready_in = 1'b0; instr = 32'h00A0_0313; pc = 32'h110;
    for (int k = 0; k < 3; k++) begin
      #1 check("lit_hold_ready", 32'(o_ready), 32'h0);
      tick();
      check("lit_hold_pc", o_pc, 32'h10C);
      check("lit_hold_rd", 32'(o_rd), 32'd5);
    end
    ready_in = 1'b1;
    tick();
    check("lit_b2b_pc", o_pc, 32'h110);
    check("lit_b2b_rd", 32'(o_rd), 32'd6);
    check("lit_b2b_valid", 32'(o_valid), 32'h1);

    // lui with flush: dropped
    instr = 32'h1234_51B7; pc = 32'h114; flush = 1'b1;
    tick();
    check("lit_flush_valid", 32'(o_valid), 32'h0);
    flush = 1'b0;

    // reset while an instruction is stalled
    instr = 32'h0070_0293; pc = 32'h118;
    tick();
    ready_in = 1'b0;
    tick();
    check("lit_stall_valid", 32'(o_valid), 32'h1);
    rst = 1'b0;
    tick();
    check("lit_rst_valid", 32'(o_valid), 32'h0);
    check("lit_rst_pc", o_pc, RESET_PC);
    rst = 1'b1; ready_in = 1'b1;

    // illegal opcode still accepted
    instr = 32'h0000_057F; pc = 32'h11C;
    tick();
    check("lit_ill_flag", 32'(o_illegal), 32'h1);
    check("lit_ill_rd", 32'(o_rd), 32'h0);
    check("lit_ill_valid", 32'(o_valid), 32'h1);
    valid = 1'b0;
    tick();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] w;
      rst      = ($urandom_range(0, 99) != 0);
      valid    = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      ready_in = ($urandom_range(0, 3) != 0);
      ex_load  = ($urandom_range(0, 2) == 0);
      ex_rd    = 5'($urandom_range(0, 7));
      wb_en    = ($urandom_range(0, 1) == 1);
      wb_reg   = 5'($urandom_range(0, 7));
      wb_val   = $urandom;
      rs1v     = $urandom;
      rs2v     = $urandom;
      pc       = $urandom & 32'hFFFF_FFFC;
      w        = $urandom;
      w[6:0]   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      instr    = w;
      tick();
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
